// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard receiver with prefix decoding (E0/F0/E1), a run-time loadable
// scan-code map and an active-low ROWS x COLS key matrix answering PPI scans.
module ps2_matrix_kbd #(
    parameter int ROWS    = 8,
    parameter int COLS    = 7,
    parameter int CLK_DIV = 250,
    parameter int TIMEOUT = 4000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  ps2_clk,
    input  logic                                  ps2_dat,
    input  logic                                  map_we,
    input  logic [8:0]                            map_addr,
    input  logic [$clog2(ROWS)+$clog2(COLS):0]    map_wdata,
    input  logic [ROWS-1:0]                       PA,
    output logic [COLS-1:0]                       PB,
    output logic                                  ev_valid,
    output logic [8:0]                            ev_code,
    output logic                                  ev_break,
    output logic                                  frame_err
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [1:0]           clk_sync, dat_sync;
    logic                 clk_prev;
    logic                 fall;
    logic [10:0]          shreg;
    logic [3:0]           bit_cnt;
    logic [TW-1:0]        to_cnt;
    logic                 byte_stb;
    logic [7:0]           byte_q;
    logic                 good, frame_bad, timeout_hit, abort;
    state_t               state, state_nx;
    logic [2:0]           rem, rem_nx;
    logic                 fire, ext, brk, rel_all;
    logic [511:0]         map_valid;
    logic [RW+CW-1:0]     map_loc [512];
    logic [8:0]           lk_addr;
    logic                 lk_valid;
    logic [RW-1:0]        lk_row;
    logic [CW-1:0]        lk_col;
    logic [ROWS-1:0][COLS-1:0] kr;

    // Sampling tick divider: one-clk pulse every CLK_DIV clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    // Two-flop synchronisers and tick-sampled PS/2 clock history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            if (tick)
                clk_prev <= clk_sync[1];
        end
    end

    assign fall        = tick & clk_prev & ~clk_sync[1];
    assign good        = ~shreg[0] & shreg[10] & (^shreg[9:1]);
    assign frame_bad   = (bit_cnt == 4'd11) & ~good;
    assign timeout_hit = (bit_cnt != 4'd0) & (bit_cnt != 4'd11) & (to_cnt == TW'(TIMEOUT));
    assign abort       = frame_bad | timeout_hit;

    // Frame assembly, frame check, timeout and byte strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            byte_stb  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (bit_cnt == 4'd11) begin
                bit_cnt   <= '0;
                to_cnt    <= '0;
                byte_stb  <= good;
                byte_q    <= shreg[8:1];
                frame_err <= ~good;
            end else if (timeout_hit) begin
                bit_cnt   <= '0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                shreg   <= {dat_sync[1], shreg[10:1]};
                bit_cnt <= bit_cnt + 1'b1;
                to_cnt  <= '0;
            end else if (tick && bit_cnt != 4'd0) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Prefix FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Prefix FSM next state and event/release-all decisions per received byte
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        fire     = 1'b0;
        ext      = 1'b0;
        brk      = 1'b0;
        rel_all  = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else if (byte_stb) begin
            unique case (state)
                S_IDLE: begin
                    case (byte_q)
                        8'hE0: state_nx = S_EXT;
                        8'hF0: state_nx = S_BRK;
                        8'hE1: begin
                            state_nx = S_SKIP;
                            rem_nx   = 3'd7;
                        end
                        8'hAA, 8'hFC, 8'h00, 8'hFF: rel_all = 1'b1;
                        default: fire = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_nx = S_EXTBRK;
                    end else begin
                        state_nx = S_IDLE;
                        fire     = (byte_q != 8'h12) && (byte_q != 8'h59);
                        ext      = 1'b1;
                    end
                end
                S_BRK: begin
                    state_nx = S_IDLE;
                    fire     = 1'b1;
                    brk      = 1'b1;
                end
                S_EXTBRK: begin
                    state_nx = S_IDLE;
                    fire     = (byte_q != 8'h12) && (byte_q != 8'h59);
                    ext      = 1'b1;
                    brk      = 1'b1;
                end
                S_SKIP: begin
                    rem_nx = rem - 1'b1;
                    if (rem == 3'd1)
                        state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Map valid bits (reset) written from the CPU port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            map_valid <= '0;
        else if (map_we)
            map_valid[map_addr] <= map_wdata[RW+CW];
    end

    // Map row/col storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (map_we)
            map_loc[map_addr] <= map_wdata[RW+CW-1:0];
    end

    assign lk_addr  = {ext, byte_q};
    assign lk_valid = map_valid[lk_addr];
    assign lk_row   = map_loc[lk_addr][RW+CW-1:CW];
    assign lk_col   = map_loc[lk_addr][CW-1:0];

    // Event outputs and key matrix; the lookup reads pre-write map contents.
    // Out-of-range row/col never matches a loop index, so it changes nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_valid <= 1'b0;
            ev_code  <= '0;
            ev_break <= 1'b0;
            kr       <= '1;
        end else begin
            ev_valid <= fire;
            if (fire) begin
                ev_code  <= lk_addr;
                ev_break <= brk;
                if (lk_valid) begin
                    for (int unsigned r = 0; r < ROWS; r++)
                        for (int unsigned c = 0; c < COLS; c++)
                            if (lk_row == RW'(r) && lk_col == CW'(c))
                                kr[r][c] <= brk;
                end
            end
            if (rel_all)
                kr <= '1;
        end
    end

    // Return lines: a column reads low when a pressed key sits on a driven-low row
    always_comb begin
        PB = '1;
        for (int unsigned c = 0; c < COLS; c++)
            for (int unsigned r = 0; r < ROWS; r++)
                PB[c] = PB[c] & (PA[r] | kr[r][c]);
    end
endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Self-checking bench for ps2_matrix_kbd: table vectors, hand-written corner
// sequences and randomized key tokens against a token-level reference model.
module tb_ps2_matrix_kbd;
    localparam int ROWS = 8;
    localparam int COLS = 7;
    localparam int TO   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       map_we = 1'b0;
    logic [8:0] map_addr = '0;
    logic [6:0] map_wdata = '0;
    logic [7:0] PA = 8'hFF;
    logic [6:0] PB;
    logic       ev_valid;
    logic [8:0] ev_code;
    logic       ev_break;
    logic       frame_err;

    ps2_matrix_kbd #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .PA(PA), .PB(PB), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_break(ev_break), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // event log: {code[16:8], brk[7], PB at event time[6:0]}
    logic [16:0] ev_q[$];
    int          ferr_cnt = 0;
    int          ev_rd = 0;
    int          ferr_base = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (ev_valid) ev_q.push_back({ev_code, ev_break, PB});
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (4) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(posedge clk);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame_of(b, 1'b0), 11);
        repeat (20) @(posedge clk);
    endtask

    task automatic map_write(input logic [8:0] a, input logic v, input logic [2:0] r, input logic [2:0] c);
        @(negedge clk);
        map_we = 1'b1; map_addr = a; map_wdata = {v, r, c};
        @(negedge clk);
        map_we = 1'b0;
    endtask

    task automatic mark();
        ev_rd = ev_q.size();
        ferr_base = ferr_cnt;
    endtask

    task automatic expect_ev(input string nm, input int n, input logic [8:0] code, input logic brk);
        chk({nm, " ev count"}, ev_q.size() - ev_rd, n);
        if (n > 0 && ev_q.size() > ev_rd) begin
            chk({nm, " ev_code"}, ev_q[ev_rd][16:8], code);
            chk({nm, " ev_break"}, ev_q[ev_rd][7], brk);
        end
        ev_rd = ev_q.size();
    endtask

    task automatic pb_at(input string nm, input logic [7:0] pa, input logic [6:0] exp);
        @(negedge clk);
        PA = pa;
        #1;
        chk(nm, PB, exp);
    endtask

    typedef struct {
        logic [7:0][7:0] b;    // byte i at b[i] (first byte in the LSBs)
        int              n;
        logic [7:0]      pa;
        int              nev;
        logic [8:0]      code;
        logic            brk;
        logic [6:0]      pb;
    } vec_t;

    vec_t tv[9];

    // token-level reference model
    logic       mv [512];
    logic [2:0] mr [512];
    logic [2:0] mc [512];
    logic [7:0][6:0] km;
    logic [7:0] pool [13];

    initial begin
        tv[0] = '{64'h1C,     1, 8'hFB, 1, 9'h01C, 1'b0, 7'h77};
        tv[1] = '{64'h1CF0,   2, 8'hFB, 1, 9'h01C, 1'b1, 7'h7F};
        tv[2] = '{64'h75E0,   2, 8'h7F, 1, 9'h175, 1'b0, 7'h6F};
        tv[3] = '{64'h75F0E0, 3, 8'h7F, 1, 9'h175, 1'b1, 7'h7F};
        tv[4] = '{64'h12E0,   2, 8'h00, 0, 9'h000, 1'b0, 7'h7F};
        tv[5] = '{64'h59F0E0, 3, 8'h00, 0, 9'h000, 1'b0, 7'h7F};
        tv[6] = '{64'h1C,     1, 8'h00, 1, 9'h01C, 1'b0, 7'h77};
        tv[7] = '{64'h75E0,   2, 8'h00, 1, 9'h175, 1'b0, 7'h67};
        tv[8] = '{64'hAA,     1, 8'h00, 0, 9'h000, 1'b0, 7'h7F};
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                 8'h42, 8'h4B, 8'h75, 8'h6B, 8'h74, 8'h72};

        // reset state
        PA = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst ev_valid", ev_valid, 0);
        chk("rst ev_code", ev_code, 0);
        chk("rst ev_break", ev_break, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst PB", PB, 7'h7F);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        map_write(9'h01C, 1'b1, 3'd2, 3'd3);
        map_write(9'h175, 1'b1, 3'd7, 3'd4);

        // table vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            PA = tv[i].pa;
            mark();
            for (int k = 0; k < tv[i].n; k++) send_byte(tv[i].b[k]);
            chk($sformatf("vec%0d ev count", i), ev_q.size() - ev_rd, tv[i].nev);
            if (tv[i].nev > 0 && ev_q.size() > ev_rd) begin
                chk($sformatf("vec%0d ev_code", i), ev_q[ev_rd][16:8], tv[i].code);
                chk($sformatf("vec%0d ev_break", i), ev_q[ev_rd][7], tv[i].brk);
                chk($sformatf("vec%0d PB at event", i), ev_q[ev_rd][6:0], tv[i].pb);
            end
            #1;
            chk($sformatf("vec%0d PB", i), PB, tv[i].pb);
            chk($sformatf("vec%0d frame_err", i), ferr_cnt - ferr_base, 0);
        end
        pb_at("released PB PA=FF", 8'hFF, 7'h7F);

        // bad parity: dropped, error pulse, matrix unchanged
        mark();
        send_bits(frame_of(8'h1C, 1'b1), 11);
        repeat (20) @(posedge clk);
        chk("parity frame_err", ferr_cnt - ferr_base, 1);
        expect_ev("parity", 0, 9'h0, 1'b0);
        pb_at("parity PB", 8'h00, 7'h7F);

        // timeout on a partial frame, then a clean frame
        mark();
        send_bits(frame_of(8'h1C, 1'b0), 6);
        repeat (150) @(posedge clk);
        chk("timeout frame_err", ferr_cnt - ferr_base, 1);
        expect_ev("timeout", 0, 9'h0, 1'b0);
        mark();
        send_byte(8'h1C);
        expect_ev("after timeout", 1, 9'h01C, 1'b0);
        chk("after timeout frame_err", ferr_cnt - ferr_base, 0);
        pb_at("after timeout PB", 8'h00, 7'h77);

        // two keys, release-all, then Pause sequence swallowed
        send_byte(8'hE0); send_byte(8'h75);
        pb_at("two keys PB", 8'h00, 7'h67);
        send_byte(8'hAA);
        pb_at("release-all PB", 8'h00, 7'h7F);
        mark();
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_ev("pause", 0, 9'h0, 1'b0);
        send_byte(8'h1C);
        expect_ev("post pause", 1, 9'h01C, 1'b0);
        pb_at("post pause PB", 8'h00, 7'h77);
        send_byte(8'hAA);

        // randomized tokens against the reference model
        for (int a = 0; a < 512; a++) mv[a] = 1'b0;
        km = '1;
        for (int p = 0; p < 13; p++) begin
            for (int e = 0; e < 2; e++) begin
                logic [8:0] ad;
                ad = {e[0], pool[p]};
                mv[ad] = ($urandom_range(0, 3) != 0);
                mr[ad] = 3'($urandom_range(0, 7));
                mc[ad] = 3'($urandom_range(0, 7));
                map_write(ad, mv[ad], mr[ad], mc[ad]);
            end
        end
        mv[9'h01C] = mv[9'h01C]; // entries 01C/175 now follow the random map
        for (int t = 0; t < 30; t++) begin
            int         kind;
            logic [7:0] code;
            logic       ex;
            logic [8:0] ad;
            kind = $urandom_range(0, 9);
            code = pool[$urandom_range(0, 12)];
            ex   = 1'($urandom_range(0, 1));
            ad   = {ex, code};
            mark();
            if (kind <= 7) begin
                if (ex) send_byte(8'hE0);
                if (kind >= 4) send_byte(8'hF0);
                send_byte(code);
                expect_ev($sformatf("rand%0d", t), 1, ad, kind >= 4);
                if (mv[ad] && mc[ad] < 3'd7) km[mr[ad]][mc[ad]] = (kind >= 4);
            end else if (kind == 8) begin
                send_byte(8'hAA);
                expect_ev($sformatf("rand%0d", t), 0, 9'h0, 1'b0);
                km = '1;
            end else begin
                send_byte(8'hE0);
                if (ex) send_byte(8'hF0);
                send_byte(ex ? 8'h59 : 8'h12);
                expect_ev($sformatf("rand%0d", t), 0, 9'h0, 1'b0);
            end
            for (int r = 0; r < ROWS; r++)
                pb_at($sformatf("rand%0d row%0d PB", t, r), ~(8'h01 << r), km[r]);
        end

        // reset with a key held: matrix and map valid bits cleared
        send_byte(8'hAA);
        map_write(9'h01C, 1'b1, 3'd2, 3'd3);
        send_byte(8'h1C);
        pb_at("held key PB", 8'h00, 7'h77);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("in reset PB", PB, 7'h7F);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post reset PB", PB, 7'h7F);
        mark();
        send_byte(8'h1C);
        expect_ev("post reset make", 1, 9'h01C, 1'b0);
        pb_at("post reset make PB", 8'h00, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_matrix_kbd.md
Name: ps2_matrix_kbd

Overview:
PS/2 keyboard receiver and scan-code-to-matrix translator with a run-time loadable key map and parametrised ROWS x COLS active-low key matrix. It replaces the fixed-case converter: prefix handling (E0/F0/E1) is an explicit FSM, and line timing, timeout and matrix size are parameters. It sits between the PS/2 pins and the PPI scan/return ports (PA/PB). The CPU or a boot loader fills the map through a write port.

Parameters:
ROWS, 8, matrix rows (scan lines on PA); 2..16
COLS, 7, matrix columns (return lines on PB); 2..16
CLK_DIV, 250, clk cycles per sampling tick; >=2
TIMEOUT, 4000, ticks without a falling PS/2 edge before a partial frame is discarded
RW, clog2(ROWS), derived, row index width
CW, clog2(COLS), derived, column index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ps2_clk  in  1  PS/2 clock pin, asynchronous
ps2_dat  in  1  PS/2 data pin, asynchronous
map_we  in  1  map write strobe, one clk
map_addr  in  9  {ext, code}; ext=1 for E0-prefixed keys
map_wdata  in  1+RW+CW  {valid, row, col}
PA  in  ROWS  scan lines, active low
PB  out  COLS  return lines, active low
ev_valid  out  1  one-clk pulse per decoded key event
ev_code  out  9  {ext, code} of the event
ev_break  out  1  1 = release, 0 = press
frame_err  out  1  one-clk pulse on a bad frame or timeout

Behaviour:
- Reset is asynchronous. It sets: matrix all 1 (all released); all 512 map valid bits to 0; FSM to IDLE; bit count 0; tick divider 0; ev_valid, frame_err, ev_break 0; ev_code 0. Map row/col storage is not reset.
- ps2_clk and ps2_dat pass through 2-flop synchronisers. A tick is a one-clk pulse every CLK_DIV clks. Lines are sampled only on ticks.
- Falling edge: synchronised ps2_clk is 0 on this tick and was 1 on the previous tick. On a falling edge, shift ps2_dat into an 11-bit register (LSB first) and increment the bit count.
- Timeout: a counter increments per tick while the bit count is nonzero and clears on each falling edge. When it reaches TIMEOUT: bit count goes to 0, frame_err pulses, and the FSM returns to IDLE.
- Frame check when the count reaches 11: start=0, stop=1, odd parity over data+parity. A good frame produces an internal byte strobe on the next clk. A bad frame pulses frame_err, drops the byte, and sends the FSM to IDLE. The count returns to 0 either way.
- Prefix FSM (on byte strobe):
  IDLE: E0->EXT; F0->BRK; E1->SKIP (remaining=7); AA/FC/00/FF->release-all; other->event(ext=0, brk=0).
  EXT: F0->EXTBRK; 12 or 59 (fake shift)->IDLE without event; other->event(ext=1, brk=0).
  BRK: event(0, 1). EXTBRK: 12/59->IDLE without event; other->event(1, 1).
  SKIP: decrement remaining; at 0 go to IDLE. No events are produced (Pause sequence).
  Every event returns the FSM to IDLE.
- Event timing: ev_valid, ev_code and ev_break are registered one clk after the byte strobe. The map lookup happens in the same clk, so the matrix bit updates on the same edge that ev_valid asserts.
- Matrix update: if map[ev_code].valid, bit [row][col] becomes ev_break (press=0, release=1). Invalid or out-of-range entries (row>=ROWS or col>=COLS) change nothing, but ev_valid still pulses. A repeated make (typematic) is idempotent.
- Release-all: every matrix bit goes to 1 in the clk after the byte strobe. No ev_valid.
- Map write: registered on map_we. If the write and a lookup hit the same address in the same clk, the lookup uses the old contents. The write takes effect on the following clk.
- PB[c] = AND over r of (PA[r] | KR[r][c]). This is purely combinational, with no clk latency from PA.
- Reset mid-frame: the partial frame is lost. Map valid bits must be reloaded after reset.

Test Plan:
- Load map 0x01C -> {1,r=2,c=3}. Send frame 1C (data 0x1C, parity 0), PA=0xFB -> ev_valid with ev_code=0x01C, ev_break=0. PB=7'h77, i.e. bit3 low. With PA=0xFF, PB=7'h7F.
- Send F0 1C -> ev_break=1, bit [2][3] returns to 1, PB=7'h7F under any PA.
- Load 0x175 -> {1,7,4}. Send E0 75 -> ev_code=0x175, row7 col4 pressed. Send E0 F0 75 -> released. Send E0 12 -> no ev_valid.
- Corrupt the parity bit of frame 1C -> frame_err one pulse, no ev_valid, matrix unchanged. Send 6 bits then idle for TIMEOUT ticks -> frame_err, the next full frame decodes correctly.
- Press two mapped keys, then send AA -> all matrix bits 1. Send E1 14 77 E1 F0 14 F0 77 -> no events, FSM in IDLE afterwards.
- Hold a key pressed, assert rst=0 for 3 clks -> PB all 1. Map valid bits cleared, so a repeated make produces ev_valid and no matrix change.
